// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port RAM between instruction fetch (IF) and load/store (MEM).
// MEM wins contention unless IF has been starved STARVE_MAX times; read data returns after MEM_LAT cycles.
module mem_port_arbiter #(
   parameter int ADDR_W     = 64,
   parameter int DATA_W     = 64,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [31:0]       if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_gnt,
   output logic              dm_rvalid,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              ram_req,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy
);

   localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam int STV_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);
   localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [STV_W-1:0]   starve_q, starve_d;
   logic               owner_dm_q, owner_dm_d;
   logic               we_q, we_d;
   logic               done, can;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         starve_q   <= '0;
         owner_dm_q <= 1'b0;
         we_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         starve_q   <= starve_d;
         owner_dm_q <= owner_dm_d;
         we_q       <= we_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      starve_d   = starve_q;
      owner_dm_d = owner_dm_q;
      we_d       = we_q;
      done       = 1'b0;
      can        = 1'b0;
      if_gnt     = 1'b0;
      dm_gnt     = 1'b0;
      if_rvalid  = 1'b0;
      dm_rvalid  = 1'b0;
      if_rdata   = '0;
      dm_rdata   = '0;
      ram_req    = 1'b0;
      ram_we     = 1'b0;
      ram_addr   = '0;
      ram_wdata  = '0;
      busy       = 1'b0;

      // Outputs are gated during reset so nothing leaks out of a dropped transaction.
      if (reset) begin
         busy = (state_q == BUSY);
         done = (state_q == BUSY) && (cnt_q == CNT_LAST);
         can  = (state_q == IDLE) || done;

         if (done) begin
            state_d = IDLE;
            if (owner_dm_q) begin
               dm_rvalid = 1'b1;
               dm_rdata  = we_q ? '0 : ram_rdata;
            end else begin
               if_rvalid = 1'b1;
               if_rdata  = ram_rdata[31:0];
            end
         end else if (state_q == BUSY) begin
            cnt_d = cnt_q + CNT_W'(1);
         end

         if (can) begin
            if (dm_req && (!if_req || starve_q != STV_MAX)) dm_gnt = 1'b1;
            else if (if_req)                               if_gnt = 1'b1;
         end

         if (dm_gnt) begin
            ram_req    = 1'b1;
            ram_we     = dm_we;
            ram_addr   = dm_addr;
            ram_wdata  = dm_wdata;
            state_d    = BUSY;
            cnt_d      = '0;
            owner_dm_d = 1'b1;
            we_d       = dm_we;
         end else if (if_gnt) begin
            ram_req    = 1'b1;
            ram_addr   = if_addr;
            state_d    = BUSY;
            cnt_d      = '0;
            owner_dm_d = 1'b0;
            we_d       = 1'b0;
         end

         // Counts only grants IF lost while asking; any idle IF cycle forgives the debt.
         if (!if_req || if_gnt)                  starve_d = '0;
         else if (dm_gnt && starve_q != STV_MAX) starve_d = starve_q + STV_W'(1);
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, contention sequence, then randomized
// traffic checked against a transaction-level reference model with its own memory image.
module tb_mem_port_arbiter;

   localparam int L  = 2;
   localparam int SM = 4;

   logic        clk = 1'b0;
   logic        reset, if_req, dm_req, dm_we;
   logic [63:0] if_addr, dm_addr, dm_wdata, ram_rdata;
   logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, ram_req, ram_we, busy;
   logic [31:0] if_rdata;
   logic [63:0] dm_rdata, ram_addr, ram_wdata;

   int nvec = 0;
   int nerr = 0;

   mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(L), .STARVE_MAX(SM)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
      .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   // Unwritten locations read back a pattern derived from the address; 0x40 holds a boot instruction.
   function automatic logic [63:0] rd_def(input logic [63:0] a);
      return (a == 64'h40) ? 64'h0000_0000_0050_0093 : {~a[31:0], a[31:0] ^ 32'h1357_9BDF};
   endfunction

   // RAM model: fixed-latency read pipe; outside a valid slot the data bus carries junk.
   logic [63:0] ramm [512];
   bit          ramv [512];
   logic [63:0] rd_dat [L];
   bit          rd_vld [L];

   function automatic logic [63:0] ram_rd(input logic [63:0] a);
      return ramv[a[11:3]] ? ramm[a[11:3]] : rd_def(a);
   endfunction

   always @(posedge clk) begin
      if (ram_req && ram_we) begin
         ramm[ram_addr[11:3]] <= ram_wdata;
         ramv[ram_addr[11:3]] <= 1'b1;
      end
      rd_vld[0] <= ram_req && !ram_we;
      rd_dat[0] <= ram_rd(ram_addr);
      for (int i = 1; i < L; i++) begin
         rd_vld[i] <= rd_vld[i-1];
         rd_dat[i] <= rd_dat[i-1];
      end
   end

   assign ram_rdata = rd_vld[L-1] ? rd_dat[L-1] : 64'hF0F0_5A5A_C3C3_0FF0;

   typedef struct {
      bit rst, ir, dr, dwe;
      logic [63:0] ia, da, dwd;
      bit ig, dg, iv, dv, rr, rwe, bsy;
      logic [63:0] raddr, rwd, drd;
      logic [31:0] ird;
   } vec_t;

   function automatic vec_t row(bit rst, bit ir, logic [63:0] ia, bit dr, bit dwe, logic [63:0] da,
                                logic [63:0] dwd, bit ig, bit dg, bit iv, bit dv, bit rr, bit rwe,
                                bit bsy, logic [63:0] raddr, logic [63:0] rwd, logic [31:0] ird,
                                logic [63:0] drd);
      vec_t v;
      v.rst = rst; v.ir = ir; v.ia = ia; v.dr = dr; v.dwe = dwe; v.da = da; v.dwd = dwd;
      v.ig = ig; v.dg = dg; v.iv = iv; v.dv = dv; v.rr = rr; v.rwe = rwe; v.bsy = bsy;
      v.raddr = raddr; v.rwd = rwd; v.ird = ird; v.drd = drd;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic apply(input vec_t v);
      @(negedge clk);
      reset = v.rst; if_req = v.ir; if_addr = v.ia;
      dm_req = v.dr; dm_we = v.dwe; dm_addr = v.da; dm_wdata = v.dwd;
      #1;
      chk("if_gnt",    64'(if_gnt),    64'(v.ig));
      chk("dm_gnt",    64'(dm_gnt),    64'(v.dg));
      chk("if_rvalid", 64'(if_rvalid), 64'(v.iv));
      chk("dm_rvalid", 64'(dm_rvalid), 64'(v.dv));
      chk("ram_req",   64'(ram_req),   64'(v.rr));
      chk("busy",      64'(busy),      64'(v.bsy));
      chk("if_rdata",  64'(if_rdata),  64'(v.ird));
      chk("dm_rdata",  dm_rdata,       v.drd);
      if (v.rr || !v.rst) begin
         chk("ram_we",   64'(ram_we), 64'(v.rwe));
         chk("ram_addr", ram_addr,    v.raddr);
         if (v.rwe || !v.rst) chk("ram_wdata", ram_wdata, v.rwd);
      end
   endtask

   // Reference model: one in-flight transaction record with its due cycle, plus a memory image.
   logic [63:0] refm [512];
   bit          refv [512];
   int          cyc, due, starve;
   bit          pend, p_dm, p_we;
   logic [63:0] p_data;

   function automatic logic [63:0] ref_rd(input logic [63:0] a);
      return refv[a[11:3]] ? refm[a[11:3]] : rd_def(a);
   endfunction

   function automatic logic [63:0] rnd_addr();
      return 64'h800 | (64'($urandom_range(0, 255)) << 3);
   endfunction

   vec_t tbl [19];
   bit   exp_ord [6] = '{0, 0, 0, 0, 1, 0};
   bit   got_ord [6];

   initial begin
      reset = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
      if_addr = '0; dm_addr = '0; dm_wdata = '0;

      //             rst ir ia     dr we da      wdata     ig dg iv dv rr rwe bsy raddr   rwd       ird          drd
      tbl[0]  = row(0, 1, 'h40,  1, 0, 'h80,  0,        0, 0, 0, 0, 0, 0, 0, 0,      0,        0,           0);
      tbl[1]  = tbl[0];
      tbl[2]  = tbl[0];
      tbl[3]  = row(1, 1, 'h40,  0, 0, 0,     0,        1, 0, 0, 0, 1, 0, 0, 'h40,   0,        0,           0);
      tbl[4]  = row(1, 0, 0,     0, 0, 0,     0,        0, 0, 0, 0, 0, 0, 1, 0,      0,        0,           0);
      tbl[5]  = row(1, 0, 0,     0, 0, 0,     0,        0, 0, 1, 0, 0, 0, 1, 0,      0,        'h00500093,  0);
      tbl[6]  = row(1, 0, 0,     1, 1, 'h100, 'hDEAD,   0, 1, 0, 0, 1, 1, 0, 'h100,  'hDEAD,   0,           0);
      tbl[7]  = row(1, 0, 0,     1, 0, 'h100, 0,        0, 0, 0, 0, 0, 0, 1, 0,      0,        0,           0);
      tbl[8]  = row(1, 0, 0,     1, 0, 'h100, 0,        0, 1, 0, 1, 1, 0, 1, 'h100,  0,        0,           0);
      tbl[9]  = tbl[4];
      tbl[10] = row(1, 0, 0,     0, 0, 0,     0,        0, 0, 0, 1, 0, 0, 1, 0,      0,        0,           'hDEAD);
      tbl[11] = row(1, 0, 0,     1, 0, 'h200, 0,        0, 1, 0, 0, 1, 0, 0, 'h200,  0,        0,           0);
      tbl[12] = row(1, 1, 'h44,  0, 0, 0,     0,        0, 0, 0, 0, 0, 0, 1, 0,      0,        0,           0);
      tbl[13] = row(1, 0, 0,     0, 0, 0,     0,        0, 0, 0, 1, 0, 0, 1, 0,      0,        0,           rd_def('h200));
      tbl[14] = row(1, 0, 0,     0, 0, 0,     0,        0, 0, 0, 0, 0, 0, 0, 0,      0,        0,           0);
      tbl[15] = row(1, 0, 0,     1, 0, 'h300, 0,        0, 1, 0, 0, 1, 0, 0, 'h300,  0,        0,           0);
      tbl[16] = row(0, 0, 0,     0, 0, 0,     0,        0, 0, 0, 0, 0, 0, 0, 0,      0,        0,           0);
      tbl[17] = tbl[14];
      tbl[18] = tbl[14];
      for (int i = 0; i < 19; i++) apply(tbl[i]);

      // Both requesters held high: DM x4, then IF, then DM again; never two grants at once.
      begin
         int ngr = 0;
         for (int c = 0; c < 30 && ngr < 6; c++) begin
            @(negedge clk);
            reset = 1'b1; if_req = 1'b1; if_addr = 64'h40;
            dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h80; dm_wdata = '0;
            #1;
            chk("contend_one_gnt", 64'(if_gnt && dm_gnt), 64'd0);
            if (if_gnt)      begin got_ord[ngr] = 1'b1; ngr++; end
            else if (dm_gnt) begin got_ord[ngr] = 1'b0; ngr++; end
         end
         chk("contend_grants", 64'(ngr), 64'd6);
         for (int k = 0; k < ngr; k++) chk("contend_order", 64'(got_ord[k]), 64'(exp_ord[k]));
      end

      // Randomized traffic; starts from a reset so the model and DUT agree on state.
      begin
         vec_t v;
         bit ir_v = 0, dr_v = 0, dwe_v = 0, last_ig = 0, last_dg = 0, rst_v, cpl, cn, gdm, gif;
         logic [63:0] ia_v = '0, da_v = '0, dwd_v = '0;
         pend = 0; starve = 0; cyc = 0; due = 0; p_dm = 0; p_we = 0; p_data = '0;
         for (int n = 0; n < 800; n++) begin
            rst_v = (n == 0) ? 1'b0 : ($urandom_range(0, 79) != 0);
            if (!ir_v || last_ig) begin
               ir_v = $urandom_range(0, 1) == 1; ia_v = rnd_addr();
            end else if ($urandom_range(0, 7) == 0) ir_v = 1'b0;
            if (!dr_v || last_dg) begin
               dr_v = $urandom_range(0, 2) != 0; dwe_v = $urandom_range(0, 1) == 1;
               da_v = rnd_addr(); dwd_v = {$urandom, $urandom};
            end
            v = row(rst_v, ir_v, ia_v, dr_v, dwe_v, da_v, dwd_v, 0,0,0,0,0,0,0, 0,0,0,0);
            if (!rst_v) begin
               pend = 0; starve = 0; last_ig = 0; last_dg = 0;
            end else begin
               cpl = pend && (due == cyc);
               v.bsy = pend;
               if (cpl) begin
                  if (p_dm) begin v.dv = 1; v.drd = p_we ? 64'd0 : p_data; end
                  else      begin v.iv = 1; v.ird = p_data[31:0]; end
                  pend = 0;
               end
               cn  = !v.bsy || cpl;
               gdm = cn && dr_v && (!ir_v || starve < SM);
               gif = cn && ir_v && !gdm;
               if (gdm) begin
                  v.dg = 1; v.rr = 1; v.rwe = dwe_v; v.raddr = da_v; v.rwd = dwd_v;
                  p_data = dwe_v ? 64'd0 : ref_rd(da_v);
                  if (dwe_v) begin refm[da_v[11:3]] = dwd_v; refv[da_v[11:3]] = 1; end
                  pend = 1; due = cyc + L; p_dm = 1; p_we = dwe_v;
               end else if (gif) begin
                  v.ig = 1; v.rr = 1; v.raddr = ia_v;
                  p_data = ref_rd(ia_v);
                  pend = 1; due = cyc + L; p_dm = 0; p_we = 0;
               end
               if (!ir_v || gif) starve = 0;
               else if (gdm)     starve = (starve < SM) ? starve + 1 : SM;
               last_ig = gif; last_dg = gdm;
            end
            cyc++;
            apply(v);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
